// File: rtl/pulse_cmd_if.sv
// pulse_cmd_if: host serial link plus decoded counter controls
interface pulse_cmd_if #(parameter int WIDTH = 16);
  logic sck;
  logic sdi;
  logic cs_n;
  logic [WIDTH-1:0] limit;
  logic load;
  logic en;
  logic [3:0] chan;
  logic busy;
  logic frame_err;
  modport master(output sck, sdi, cs_n, input limit, load, en, chan, busy, frame_err);
  modport slave(input sck, sdi, cs_n, output limit, load, en, chan, busy, frame_err);
endinterface

// File: rtl/pulse_cmd_decoder.sv
// pulse_cmd_decoder: serial command frames to limit/load/en for downwardCounter
module pulse_cmd_decoder #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  pulse_cmd_if.slave bus
);
  localparam int N = 8 + WIDTH;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] NB = CW'(N);
  localparam logic [CW-1:0] NOV = CW'(N + 1);
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_EN = 4'h2;
  localparam logic [3:0] OP_DIS = 4'h3;
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, APPLY, PULSE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sck_q, sdi_q, cs_q;
  logic sck_d, cs_d;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] sh, sh_n;
  logic [WIDTH-1:0] limit_q, limit_n;
  logic [3:0] chan_q, chan_n;
  logic en_q, en_n, busy_q, busy_n, err_q, err_n, load_q, load_n;
  logic sck_s, sdi_s, cs_s, sck_rise, cs_fall, cs_rise, pulse;
  logic [3:0] op;
  // cs_n chain resets low so a frame held low across reset release cannot start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_q <= '0;
      sdi_q <= '0;
      cs_q <= '0;
      sck_d <= 1'b0;
      cs_d <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], bus.sck};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], bus.sdi};
      cs_q <= {cs_q[SYNC_STAGES-2:0], bus.cs_n};
      sck_d <= sck_s;
      cs_d <= cs_s;
    end
  assign sck_s = sck_q[SYNC_STAGES-1];
  assign sdi_s = sdi_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = cs_s & ~cs_d;
  assign op = sh[N-1 -: 4];
  assign pulse = (op == OP_LOAD) && en_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      limit_q <= '0;
      chan_q <= '0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      limit_q <= limit_n;
      chan_q <= chan_n;
      en_q <= en_n;
      busy_q <= busy_n;
      err_q <= err_n;
      load_q <= load_n;
    end
  // Decode results land on the CHECK->APPLY edge so limit settles a full cycle before load
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    limit_n = limit_q;
    chan_n = chan_q;
    en_n = en_q;
    busy_n = busy_q;
    err_n = err_q;
    load_n = 1'b0;
    case (state)
      IDLE:
        if (cs_fall) begin
          state_n = SHIFT;
          cnt_n = '0;
          busy_n = 1'b1;
        end
      SHIFT:
        if (cs_rise) state_n = CHECK;
        else if (sck_rise && !cs_s) begin
          sh_n = {sh[N-2:0], sdi_s};
          cnt_n = (cnt == NOV) ? cnt : cnt + 1'b1;
        end
      CHECK:
        if (cnt != NB) begin
          err_n = 1'b1;
          busy_n = 1'b0;
          state_n = IDLE;
        end else begin
          state_n = APPLY;
          busy_n = pulse;
          err_n = !(op inside {OP_LOAD, OP_EN, OP_DIS});
          limit_n = (op == OP_LOAD) ? sh[WIDTH-1:0] : limit_q;
          chan_n = (op == OP_LOAD) ? sh[N-5 -: 4] : chan_q;
          en_n = (op == OP_EN) ? 1'b1 : (op == OP_DIS) ? 1'b0 : en_q;
        end
      APPLY: begin
        state_n = pulse ? PULSE : IDLE;
        load_n = pulse;
      end
      PULSE: begin
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.limit = limit_q;
  assign bus.load = load_q;
  assign bus.en = en_q;
  assign bus.chan = chan_q;
  assign bus.busy = busy_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_pulse_cmd_decoder.sv
// tb_pulse_cmd_decoder: directed frames against a frame-level model checked every cycle
module tb_pulse_cmd_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pulse_cmd_if #(.WIDTH(16)) bus();
  pulse_cmd_decoder #(.WIDTH(16), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int load_cnt = 0;
  bit go = 1'b0;
  bit prev_load = 1'b0;
  logic [15:0] q, q_after_load;
  logic [15:0] m_limit = '0;
  logic [3:0] m_chan = '0;
  logic m_en = 1'b0, m_load = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // Downstream downwardCounter stand-in
  always @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (bus.load) q <= bus.limit;
    else if (bus.en && q != 0) q <= q - 1'b1;
  always @(negedge clk) begin
    if (go) begin
      chk("limit", 32'(bus.limit), 32'(m_limit));
      chk("chan", 32'(bus.chan), 32'(m_chan));
      chk("en", 32'(bus.en), 32'(m_en));
      chk("load", 32'(bus.load), 32'(m_load));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("frame_err", 32'(bus.frame_err), 32'(m_err));
    end
    if (prev_load) q_after_load = q;
    if (bus.load) load_cnt++;
    prev_load = bus.load;
  end
  task automatic shift_bits(input logic [31:0] bits, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.sdi = bits[i];
      repeat (4) @(negedge clk);
      bus.sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.sck = 1'b0;
    end
  endtask
  task automatic start_frame();
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_busy = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic frame(input logic [31:0] bits, input int nb);
    logic [3:0] op;
    start_frame();
    shift_bits(bits, nb - 1, 0);
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    op = bits[23:20];
    if (nb != 24) begin
      m_err = 1'b1;
      m_busy = 1'b0;
    end else if (op == 4'h1) begin
      m_limit = bits[15:0];
      m_chan = bits[19:16];
      m_err = 1'b0;
      if (m_en) begin
        @(posedge clk);
        #1 m_load = 1'b1;
        @(posedge clk);
        #1 m_load = 1'b0;
      end
      m_busy = 1'b0;
    end else if (op == 4'h2 || op == 4'h3) begin
      m_en = (op == 4'h2);
      m_err = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_err = 1'b1;
      m_busy = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lc;
    bus.sck = 1'b0;
    bus.sdi = 1'b0;
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_limit", 32'(bus.limit), 32'h0);
    chk("rst_en", 32'(bus.en), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    frame(32'h200000, 24);
    chk("enable_en", 32'(bus.en), 32'h1);
    chk("enable_noload", 32'(load_cnt), 32'h0);
    frame(32'h1501F4, 24);
    chk("load_limit", 32'(bus.limit), 32'h01F4);
    chk("load_chan", 32'(bus.chan), 32'h5);
    chk("load_once", 32'(load_cnt), 32'h1);
    chk("counter_q", 32'(q_after_load), 32'd500);
    frame(32'h300000, 24);
    frame(32'h1200FF, 24);
    chk("noen_limit", 32'(bus.limit), 32'h00FF);
    chk("noen_noload", 32'(load_cnt), 32'h1);
    frame(32'h200000, 24);
    frame(32'h120010, 24);
    chk("reload_limit", 32'(bus.limit), 32'h0010);
    chk("reload_pulse", 32'(load_cnt), 32'h2);
    frame(32'hABCDE, 20);
    chk("short_err", 32'(bus.frame_err), 32'h1);
    chk("short_limit", 32'(bus.limit), 32'h0010);
    frame(32'h3ABCDEF0, 30);
    chk("long_err", 32'(bus.frame_err), 32'h1);
    chk("long_en", 32'(bus.en), 32'h1);
    frame(32'h200000, 24);
    chk("valid_clears_err", 32'(bus.frame_err), 32'h0);
    frame(32'hA51234, 24);
    chk("badop_err", 32'(bus.frame_err), 32'h1);
    chk("badop_chan", 32'(bus.chan), 32'h2);
    frame(32'h300000, 24);
    chk("disable_en", 32'(bus.en), 32'h0);
    chk("disable_err", 32'(bus.frame_err), 32'h0);
    frame(32'h200000, 24);
    lc = load_cnt;
    start_frame();
    shift_bits(32'h131234, 23, 12);
    @(negedge clk);
    #2 rst_n = 1'b0;
    {m_limit, m_chan, m_en, m_load, m_busy, m_err} = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    shift_bits(32'h131234, 11, 0);
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_noload", 32'(load_cnt), 32'(lc));
    chk("midrst_limit", 32'(bus.limit), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    frame(32'h200000, 24);
    frame(32'h140000, 24);
    chk("zero_chan", 32'(bus.chan), 32'h4);
    chk("zero_pulse", 32'(load_cnt), 32'(lc + 1));
    go = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
